// File: rtl/multicycle_add_sub_32_pkg.sv
// Shared constants and state encoding for the byte-serial 32-bit adder/subtractor.
// The optional overflow flag is enabled by defining ADD_OVF_EN.
package multicycle_add_sub_32_pkg;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int BEATS = 4;

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multicycle_add_sub_32_adder_slice_8.sv
// 8-bit carry-select adder slice: ripple low nibble, high nibble precomputed for both carries.
// Cout_1 is the carry into bit 7, recovered from the sum and operand bits.
module adder_slice_8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] Sout,
    output logic       Cout,
    output logic       Cout_1
);

    logic [4:0] lo_sum;
    logic [4:0] hi_sum0;
    logic [4:0] hi_sum1;

    assign lo_sum  = {1'b0, A[3:0]} + {1'b0, B[3:0]} + {4'b0, Cin};
    assign hi_sum0 = {1'b0, A[7:4]} + {1'b0, B[7:4]};
    assign hi_sum1 = hi_sum0 + 5'd1;

    assign Sout   = {(lo_sum[4] ? hi_sum1[3:0] : hi_sum0[3:0]), lo_sum[3:0]};
    assign Cout   = lo_sum[4] ? hi_sum1[4] : hi_sum0[4];
    // sum bit = a ^ b ^ carry_in, so the carry into bit 7 falls out directly
    assign Cout_1 = Sout[7] ^ A[7] ^ B[7];

endmodule

// File: rtl/multicycle_add_sub_32.sv
// 32-bit add/subtract computed one byte per cycle through a single shared 8-bit slice.
// Define ADD_OVF_EN to add the signed-overflow output and its logic.
module multicycle_add_sub_32
    import multicycle_add_sub_32_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Sout,
    output logic        Cout
`ifdef ADD_OVF_EN
    ,
    output logic        ovf
`endif
);

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry_reg;
    logic               cout_reg;
    logic [1:0]         beat_reg;
    logic               accept;
    logic               busy;
    logic [SLICE-1:0]   slice_a;
    logic [SLICE-1:0]   slice_b;
    logic [SLICE-1:0]   slice_sum;
    logic               slice_cout;
    logic               slice_cout_1;

    // in_ready is forced low while reset is asserted
    assign in_ready  = resetn && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign busy      = (state_reg == BUSY);
    assign out_valid = (state_reg == DONE);
    assign Cout      = cout_reg;

    assign slice_a = a_reg[beat_reg * SLICE +: SLICE];
    assign slice_b = b_reg[beat_reg * SLICE +: SLICE];

    adder_slice_8 u_slice (
        .A      (slice_a),
        .B      (slice_b),
        .Cin    (carry_reg),
        .Sout   (slice_sum),
        .Cout   (slice_cout),
        .Cout_1 (slice_cout_1)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (beat_reg == LAST_BEAT) state_next = DONE;
            DONE:    if (out_ready) state_next = in_valid ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            beat_reg  <= 2'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                // subtraction is A + ~B + 1: invert B here, inject the +1 as the first carry
                a_reg     <= A;
                b_reg     <= B ^ {WIDTH{sub}};
                carry_reg <= sub;
                beat_reg  <= 2'd0;
            end else if (busy) begin
                carry_reg <= slice_cout;
                beat_reg  <= beat_reg + 2'd1;
                if (beat_reg == LAST_BEAT) cout_reg <= slice_cout;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_byte
            logic [SLICE-1:0] byte_reg;

            always_ff @(posedge clock) begin
                if (!resetn) begin
                    byte_reg <= '0;
                end else if (busy && (beat_reg == 2'(gi))) begin
                    byte_reg <= slice_sum;
                end
            end

            assign Sout[gi*SLICE +: SLICE] = byte_reg;
        end
    endgenerate

`ifdef ADD_OVF_EN
    logic ovf_reg;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ovf_reg <= 1'b0;
        end else if (busy && (beat_reg == LAST_BEAT)) begin
            ovf_reg <= slice_cout ^ slice_cout_1;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: doc/multicycle_add_sub_32.md
MULTICYCLE_ADD_SUB_32 -- requirements
Module: multicycle_add_sub_32

Interface
REQ-001 SHALL have port: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  operand request valid.
REQ-004 SHALL have port: in_ready  output  1  block can accept an operand pair this cycle.
REQ-005 SHALL have port: A  input  32  first operand.
REQ-006 SHALL have port: B  input  32  second operand.
REQ-007 SHALL have port: sub  input  1  0 = A+B, 1 = A-B.
REQ-008 SHALL have port: out_valid  output  1  result valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: Sout  output  32  sum/difference.
REQ-011 SHALL have port: Cout  output  1  carry out of bit 31.
REQ-012 SHALL have port: ovf  output  1  signed overflow (present only with ADD_OVF_EN).

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE.
REQ-014 SHALL drive in_ready = 1 in IDLE, or in DONE when out_ready = 1; 0 otherwise.
REQ-015 SHALL accept on a rising edge with in_valid & in_ready: register A, B XOR {32{sub}}, carry = sub, beat = 0; go to BUSY.
REQ-016 SHALL, in BUSY, compute one 8-bit slice per cycle (bits 8*beat+7:8*beat) from registered operands and carry; write the result byte, update carry with slice Cout, increment beat.
REQ-017 SHALL process the low byte first, the high byte last; after beat 3 go to DONE.
REQ-018 SHALL assert out_valid in DONE only; out_valid rises exactly 4 cycles after the accept edge.
REQ-019 SHALL hold Sout, Cout, ovf stable while out_valid = 1 and out_ready = 0.
REQ-020 SHALL, in DONE with out_ready = 1: go to BUSY if in_valid = 1 (back-to-back accept, same edge), else go to IDLE.
REQ-021 SHALL ignore in_valid, A, B, sub while in BUSY.
REQ-022 SHALL set Cout = final carry; for sub = 1, Cout = 1 means no borrow.
REQ-023 SHALL compute all arithmetic modulo 2^32; no saturation.

Reset
REQ-024 SHALL, when resetn = 0 at a rising edge, enter IDLE and clear Sout, Cout, ovf, carry, beat, out_valid to 0, from any state including mid-BUSY; the in-flight operation is discarded.
REQ-025 SHALL drive in_ready = 0 during the reset cycle and 1 on the first cycle after reset.

Configuration
REQ-026 SHALL compile ovf logic and port only when macro ADD_OVF_EN is defined.
REQ-027 SHALL, with ADD_OVF_EN, set ovf = carry into bit 31 XOR carry out of bit 31, captured from the beat-3 slice.
REQ-028 SHALL, without ADD_OVF_EN, omit the port and all ovf logic; all other behaviour is unchanged.

Structure
REQ-029 SHALL place constants in a shared package: WIDTH = 32, SLICE = 8, BEATS = 4, and the state encoding IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2.
REQ-030 SHALL instantiate exactly one 8-bit carry-select slice sub-module, adder_slice_8, with ports A, B, Cin, Sout, Cout, and Cout_1 (carry into bit 7), reused for every beat.

Verification
REQ-031 SHALL test add: A=0x0000_00FF, B=0x0000_0001, sub=0 -> Sout=0x0000_0100, Cout=0, ovf=0, out_valid 4 cycles after accept.
REQ-032 SHALL test sub with borrow: A=0x0000_0000, B=0x0000_0001, sub=1 -> Sout=0xFFFF_FFFF, Cout=0, ovf=0.
REQ-033 SHALL test signed overflow: A=0x7FFF_FFFF, B=0x0000_0001, sub=0 -> Sout=0x8000_0000, Cout=0, ovf=1; and A=0xFFFF_FFFF, B=0x1 -> Sout=0, Cout=1, ovf=0.
REQ-034 SHALL test backpressure and back-to-back: hold out_ready=0 for 3 cycles -> result stable, in_ready=0; then out_ready=1 with in_valid=1 -> new operation accepted on the same edge, next out_valid 4 cycles later.
REQ-035 SHALL test reset mid-operation: resetn=0 at beat 2 -> IDLE next cycle, all outputs 0, no out_valid for the discarded operation.
